// File: rtl/flash_pkg.sv
// Shared types and default timing for the parallel-flash burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_ROM_ADDR  = 23;
    localparam int DEF_PAGE_SIZE = 3;
    localparam int DEF_P_MISS    = 4;
    localparam int DEF_P_HIT     = 2;
    localparam int DEF_LEN_BITS  = 4;

endpackage

// File: rtl/flash_wait_timer.sv
// Access-time counter: restarts at 0 on start, counts while en, flags the last wait cycle.
// Latency: done is combinational from the count, asserted when count == top-1.
// Backpressure: none; the owner decides when to start and enable it.
module flash_wait_timer
    import flash_pkg::*;
#(
    parameter int P_MISS = DEF_P_MISS,
    localparam int CW    = $clog2(P_MISS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          en,
    input  logic [CW-1:0] top,
    output logic          done
);

    logic [CW-1:0] count;

    // Count cycles spent waiting on the flash; start always wins and zeroes the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == (top - CW'(1)));

endmodule

// File: rtl/flash_burst_reader.sv
// Burst reader for an asynchronous page-mode NOR flash: one word per WAIT/HOLD round trip.
// Latency: P_MISS cycles for a page miss, P_HIT for a page hit, from address update to out_valid.
// Backpressure: a word is held stable in HOLD until out_ready; requests only taken in IDLE.
module flash_burst_reader
    import flash_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ROM_ADDR  = DEF_ROM_ADDR,
    parameter int PAGE_SIZE = DEF_PAGE_SIZE,
    parameter int P_MISS    = DEF_P_MISS,
    parameter int P_HIT     = DEF_P_HIT,
    parameter int LEN_BITS  = DEF_LEN_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ROM_ADDR-1:0] req_addr,
    input  logic [LEN_BITS-1:0] req_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                busy,
    input  logic [WIDTH-2:0]    SF_D,
    input  logic                SF_D0,
    output logic [ROM_ADDR:0]   SF_A,
    output logic                SF_CE0,
    output logic                SF_OE,
    output logic                SF_WE,
    output logic                SF_BYTE
);

    localparam int CW = $clog2(P_MISS + 1);
    localparam int PW = ROM_ADDR - PAGE_SIZE;

    state_t              state;
    logic [ROM_ADDR-1:0] cur_addr;
    logic [LEN_BITS-1:0] remain;
    logic [CW-1:0]       top;
    logic [PW-1:0]       page;
    logic                page_valid;

    logic                accept;
    logic                advance;
    logic                start;
    logic                done;
    logic [ROM_ADDR-1:0] next_addr;
    logic [PW-1:0]       next_page;
    logic                hit;
    logic [CW-1:0]       next_top;

    // Chip is permanently selected and read-only in 16-bit mode.
    assign SF_CE0  = 1'b0;
    assign SF_OE   = 1'b0;
    assign SF_WE   = 1'b1;
    assign SF_BYTE = 1'b1;
    assign SF_A    = {cur_addr, 1'b0};

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Address about to be presented and whether it stays in the open page.
    always_comb begin
        accept    = (state == IDLE) && req_valid;
        advance   = (state == HOLD) && out_ready && (remain != '0);
        start     = accept || advance;
        next_addr = accept ? req_addr : (cur_addr + ROM_ADDR'(1));
        next_page = next_addr[ROM_ADDR-1:PAGE_SIZE];
        hit       = page_valid && (next_page == page);
        next_top  = hit ? CW'(P_HIT) : CW'(P_MISS);
    end

    flash_wait_timer #(
        .P_MISS (P_MISS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .en    (state == WAIT),
        .top   (top),
        .done  (done)
    );

    // Burst sequencer: latch request, wait out the access time, hold the word until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remain     <= '0;
            top        <= '0;
            page       <= '0;
            page_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr   <= next_addr;
                        remain     <= req_len;
                        top        <= next_top;
                        page       <= next_page;
                        page_valid <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        out_data  <= {SF_D, SF_D0};
                        out_valid <= 1'b1;
                        out_last  <= (remain == '0);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (remain == '0) begin
                            state <= IDLE;
                        end else begin
                            cur_addr   <= next_addr;
                            remain     <= remain - LEN_BITS'(1);
                            top        <= next_top;
                            page       <= next_page;
                            page_valid <= 1'b1;
                            state      <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader with a combinational flash model.
// Latency: checks page-miss/page-hit timing word by word.
// Backpressure: exercises out_ready stalls and ignored requests while busy.
module tb_flash_burst_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [22:0] req_addr;
    logic [3:0]  req_len;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic [14:0] SF_D;
    logic        SF_D0;
    logic [23:0] SF_A;
    logic        SF_CE0, SF_OE, SF_WE, SF_BYTE;

    int errors = 0;
    int checks = 0;

    // Flash model: word at a given word address is its low 16 bits xor a constant.
    logic [15:0] flash_word;
    assign flash_word = SF_A[16:1] ^ 16'h5A5A;
    assign SF_D  = flash_word[15:1];
    assign SF_D0 = flash_word[0];

    always #5 clk = ~clk;

    flash_burst_reader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .SF_D      (SF_D),
        .SF_D0     (SF_D0),
        .SF_A      (SF_A),
        .SF_CE0    (SF_CE0),
        .SF_OE     (SF_OE),
        .SF_WE     (SF_WE),
        .SF_BYTE   (SF_BYTE)
    );

    function automatic logic [15:0] exp_data(input logic [22:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle starting at a falling edge.
    task automatic issue(input string tag, input logic [22:0] a, input logic [3:0] l);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        #1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges from the reference edge until out_valid, then check the word.
    task automatic wait_word(input string tag, input int exp_lat, input logic [22:0] a,
                             input logic exp_last, input logic consume);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_sfa"}, 32'(SF_A), 32'({a, 1'b0}));
        check({tag, "_data"}, 32'(out_data), 32'(exp_data(a)));
        check({tag, "_last"}, 32'(out_last), 32'(exp_last));
        if (consume) begin
            @(posedge clk);
            #1;
            check({tag, "_taken"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sfa", 32'(SF_A), 32'd0);
        check("strobes", 32'({SF_CE0, SF_OE, SF_WE, SF_BYTE}), 32'b0011);
        @(negedge clk);
        reset = 1'b0;

        // Single word after reset: always a miss.
        issue("single", 23'h000010, 4'd0);
        wait_word("single_w0", 4, 23'h000010, 1'b1, 1'b1);
        check("single_idle", 32'(busy), 32'd0);

        // Crosses a page boundary mid-burst: miss, hit, miss.
        issue("cross", 23'h00000E, 4'd2);
        wait_word("cross_w0", 4, 23'h00000E, 1'b0, 1'b1);
        wait_word("cross_w1", 2, 23'h00000F, 1'b0, 1'b1);
        wait_word("cross_w2", 4, 23'h000010, 1'b1, 1'b1);

        // Four-word burst inside one page: miss then three hits.
        issue("burst", 23'h000008, 4'd3);
        wait_word("burst_w0", 4, 23'h000008, 1'b0, 1'b1);
        wait_word("burst_w1", 2, 23'h000009, 1'b0, 1'b1);
        wait_word("burst_w2", 2, 23'h00000A, 1'b0, 1'b1);
        wait_word("burst_w3", 2, 23'h00000B, 1'b1, 1'b1);

        // Address wrap from the top of the array to zero is a miss.
        issue("wrap", 23'h7FFFFF, 4'd1);
        wait_word("wrap_w0", 4, 23'h7FFFFF, 1'b0, 1'b1);
        wait_word("wrap_w1", 4, 23'h000000, 1'b1, 1'b1);

        // Stall in HOLD: word stable, requests ignored.
        out_ready = 1'b0;
        issue("stall", 23'h000009, 4'd0);
        wait_word("stall_w0", 4, 23'h000009, 1'b1, 1'b0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = 23'h000300 + 23'(i);
            req_len   = 4'd5;
            @(posedge clk);
            #1;
            check("stall_data", 32'(out_data), 32'(held));
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_busy", 32'(busy), 32'd0);

        // New burst in the stored page is a hit.
        issue("rehit", 23'h00000A, 4'd0);
        wait_word("rehit_w0", 2, 23'h00000A, 1'b1, 1'b1);

        // Reset during WAIT of the second word of a burst.
        issue("abort", 23'h000020, 4'd3);
        wait_word("abort_w0", 4, 23'h000020, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_sfa", 32'(SF_A), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_word", 32'(out_valid), 32'd0);
        issue("postrst", 23'h000021, 4'd0);
        wait_word("postrst_w0", 4, 23'h000021, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
